// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: decodes R-type instruction words, reads operands from an
// internal 32x32 register file, drives an external ALU and writes the result back.
module alu_cmd_issuer #(
  parameter int unsigned WIDTH    = 32,
  parameter logic [3:0]  SEL_IDLE = 4'b1111,
  parameter logic [3:0]  SEL_ILL  = 4'b0111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  input  logic             init_we,
  input  logic [4:0]       init_addr,
  input  logic [WIDTH-1:0] init_data,
  input  logic [4:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_zf,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             illegal
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_WB
  } state_t;

  state_t state, state_nxt;

  logic [31:0]      instr_q;
  logic [WIDTH-1:0] op_a, op_b;
  logic [3:0]       sel_q;
  logic [WIDTH-1:0] rf [32];

  logic [4:0]       rs, rt, rd;
  logic [3:0]       dec_sel;
  logic             dec_ill;
  logic [WIDTH-1:0] rd_a, rd_b;

  assign rs = instr_q[25:21];
  assign rt = instr_q[20:16];
  assign rd = instr_q[15:11];

  assign rd_a     = (rs == 5'd0)       ? '0 : rf[rs];
  assign rd_b     = (rt == 5'd0)       ? '0 : rf[rt];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : rf[dbg_addr];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake/ALU-drive outputs
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_sel     = SEL_IDLE;
    case (state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = ST_DECODE;
      end
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC: begin
        alu_a     = op_a;
        alu_b     = op_b;
        alu_sel   = sel_q;
        state_nxt = ST_WB;
      end
      ST_WB: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // funct/opcode to ALU select decode
  always_comb begin
    dec_sel = SEL_ILL;
    dec_ill = 1'b0;
    if (instr_q[31:26] != 6'd0) begin
      dec_ill = 1'b1;
    end else begin
      case (instr_q[5:0])
        6'h24:   dec_sel = 4'b0000;
        6'h25:   dec_sel = 4'b0001;
        6'h20:   dec_sel = 4'b0010;
        6'h22:   dec_sel = 4'b0011;
        6'h2A:   dec_sel = 4'b0100;
        6'h27:   dec_sel = 4'b0101;
        default: dec_ill = 1'b1;
      endcase
    end
  end

  // Instruction latch, operand fetch and ALU result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      op_a    <= '0;
      op_b    <= '0;
      sel_q   <= SEL_IDLE;
      illegal <= 1'b0;
      result  <= '0;
      zf      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (instr_valid) instr_q <= instr;
        ST_DECODE: begin
          op_a    <= rd_a;
          op_b    <= rd_b;
          sel_q   <= dec_sel;
          illegal <= dec_ill;
        end
        ST_EXEC: begin
          result <= alu_r;
          zf     <= alu_zf;
        end
        default: ;
      endcase
    end
  end

  // Register file: preload in IDLE, writeback at end of WB; r0 never written
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
    end else if (state == ST_IDLE) begin
      if (init_we && init_addr != 5'd0) rf[init_addr] <= init_data;
    end else if (state == ST_WB) begin
      if (!illegal && rd != 5'd0) rf[rd] <= result;
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed testbench for alu_cmd_issuer with a behavioural ALU attached.
module tb_alu_cmd_issuer;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        init_we;
  logic [4:0]  init_addr;
  logic [31:0] init_data;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_r;
  logic        alu_zf;
  logic        done;
  logic [31:0] result;
  logic        zf;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  alu_cmd_issuer #(
    .WIDTH(32),
    .SEL_IDLE(4'b1111),
    .SEL_ILL(4'b0111)
  ) dut (
    .clk(clk),
    .rst(rst),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_ready(instr_ready),
    .init_we(init_we),
    .init_addr(init_addr),
    .init_data(init_data),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_sel(alu_sel),
    .alu_r(alu_r),
    .alu_zf(alu_zf),
    .done(done),
    .result(result),
    .zf(zf),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: select codes as seen by the issuer; unknown select gives 0
  always_comb begin
    case (alu_sel)
      4'b0000: alu_r = alu_a & alu_b;
      4'b0001: alu_r = alu_a | alu_b;
      4'b0010: alu_r = alu_a + alu_b;
      4'b0011: alu_r = alu_a - alu_b;
      4'b0100: alu_r = (alu_a < alu_b) ? 32'd1 : 32'd0;
      4'b0101: alu_r = ~(alu_a | alu_b);
      default: alu_r = 32'd0;
    endcase
    alu_zf = (alu_r == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {6'd0, rs, rt, rd, 5'd0, funct};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    init_we   = 1'b1;
    init_addr = a;
    init_data = d;
    step();
    init_we   = 1'b0;
  endtask

  // Issue one instruction from IDLE and follow it through DECODE/EXEC/WB
  task automatic issue(input string tag, input logic [31:0] w, input logic [3:0] exp_sel,
                       input logic [31:0] exp_res, input logic exp_zf, input logic exp_ill,
                       input logic [31:0] old);
    logic [4:0]  rd;
    logic [31:0] exp_new;
    int          waited;
    rd      = w[15:11];
    exp_new = (!exp_ill && rd != 5'd0) ? exp_res : old;
    waited  = 0;
    while (!instr_ready && waited < 8) begin
      step();
      waited++;
    end
    check({tag, " ready"}, {31'd0, instr_ready}, 32'd1);
    dbg_addr    = rd;
    instr_valid = 1'b1;
    instr       = w;
    step();
    instr_valid = 1'b0;
    init_we     = 1'b0;
    check({tag, " dec_sel"}, {28'd0, alu_sel}, 32'hF);
    check({tag, " dec_ready"}, {31'd0, instr_ready}, 32'd0);
    step();
    check({tag, " exec_sel"}, {28'd0, alu_sel}, {28'd0, exp_sel});
    check({tag, " exec_done"}, {31'd0, done}, 32'd0);
    step();
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " result"}, result, exp_res);
    check({tag, " zf"}, {31'd0, zf}, {31'd0, exp_zf});
    check({tag, " illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
    check({tag, " wb_old"}, dbg_data, old);
    step();
    check({tag, " done_clr"}, {31'd0, done}, 32'd0);
    check({tag, " rd_after"}, dbg_data, exp_new);
  endtask

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    init_we     = 1'b0;
    init_addr   = '0;
    init_data   = '0;
    dbg_addr    = '0;
    step();
    step();
    check("rst ready", {31'd0, instr_ready}, 32'd1);
    check("rst sel", {28'd0, alu_sel}, 32'hF);
    check("rst a", alu_a, 32'd0);
    check("rst b", alu_b, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst result", result, 32'd0);
    check("rst zf", {31'd0, zf}, 32'd0);
    check("rst illegal", {31'd0, illegal}, 32'd0);
    rst = 1'b0;
    step();

    preload(5'd1, 32'd1);
    preload(5'd2, 32'd1);
    issue("add r3", 32'h00221820, 4'b0010, 32'd2, 1'b0, 1'b0, 32'd0);

    preload(5'd1, 32'd2);
    issue("sub r4", rtype(5'd1, 5'd2, 5'd4, 6'h22), 4'b0011, 32'd1, 1'b0, 1'b0, 32'd0);
    issue("and r5", rtype(5'd1, 5'd2, 5'd5, 6'h24), 4'b0000, 32'd0, 1'b1, 1'b0, 32'd0);
    issue("or r6",  rtype(5'd1, 5'd2, 5'd6, 6'h25), 4'b0001, 32'd3, 1'b0, 1'b0, 32'd0);
    issue("slt r7", rtype(5'd1, 5'd2, 5'd7, 6'h2A), 4'b0100, 32'd0, 1'b1, 1'b0, 32'd0);
    issue("nor r8", rtype(5'd1, 5'd2, 5'd8, 6'h27), 4'b0101, 32'hFFFFFFFC, 1'b0, 1'b0, 32'd0);
    dbg_addr = 5'd3;
    #1 check("r3 kept", dbg_data, 32'd2);

    issue("sub r0r0", rtype(5'd0, 5'd0, 5'd5, 6'h22), 4'b0011, 32'd0, 1'b1, 1'b0, 32'd0);
    preload(5'd1, 32'd1);
    issue("add rd0", rtype(5'd1, 5'd1, 5'd0, 6'h20), 4'b0010, 32'd2, 1'b0, 1'b0, 32'd0);
    preload(5'd0, 32'hDEAD);
    dbg_addr = 5'd0;
    #1 check("r0 preload", dbg_data, 32'd0);

    // preload on the same edge as the handshake is visible to DECODE
    init_we   = 1'b1;
    init_addr = 5'd2;
    init_data = 32'd5;
    issue("pre+hs", rtype(5'd2, 5'd2, 5'd10, 6'h20), 4'b0010, 32'd10, 1'b0, 1'b0, 32'd0);

    preload(5'd9, 32'h55);
    issue("ill funct", rtype(5'd1, 5'd2, 5'd9, 6'h26), 4'b0111, 32'd0, 1'b1, 1'b1, 32'h55);
    issue("ill opc", {6'h08, 5'd1, 5'd1, 5'd9, 5'd0, 6'h20}, 4'b0111, 32'd0, 1'b1, 1'b1, 32'h55);

    // continuous valid, three dependent r1=r1+r1, init_we pulsed in EXEC
    preload(5'd1, 32'd1);
    dbg_addr    = 5'd1;
    instr       = rtype(5'd1, 5'd1, 5'd1, 6'h20);
    instr_valid = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      check($sformatf("stream ready %0d", i), {31'd0, instr_ready}, (i % 4 == 0) ? 32'd1 : 32'd0);
      check($sformatf("stream done %0d", i), {31'd0, done}, (i % 4 == 3) ? 32'd1 : 32'd0);
      if (i == 12) begin
        instr_valid = 1'b0;
      end else begin
        if (i % 4 == 2) begin
          init_we   = 1'b1;
          init_addr = 5'd1;
          init_data = 32'h77;
        end else begin
          init_we = 1'b0;
        end
        step();
      end
    end
    init_we = 1'b0;
    check("stream r1", dbg_data, 32'd8);

    // reset in EXEC of a SUB targeting r9
    dbg_addr    = 5'd9;
    instr       = rtype(5'd9, 5'd0, 5'd9, 6'h22);
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    check("abort exec_sel", {28'd0, alu_sel}, 32'h3);
    rst = 1'b1;
    step();
    check("abort done", {31'd0, done}, 32'd0);
    check("abort sel", {28'd0, alu_sel}, 32'hF);
    check("abort ready", {31'd0, instr_ready}, 32'd1);
    check("abort result", result, 32'd0);
    for (int r = 0; r < 32; r++) begin
      dbg_addr = r[4:0];
      #1 check($sformatf("abort r%0d", r), dbg_data, 32'd0);
    end
    rst = 1'b0;
    step();
    check("post rst done", {31'd0, done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
